// File: rtl/dm1_7_pkg.sv
// Shared datapath constants for the distribution demux and the processor datapath muxes.
package dm1_7_pkg;
   localparam int unsigned DW    = 16;
   localparam int unsigned NCH   = 7;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 16;

   // True when a select addresses an existing channel.
   function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int unsigned nch);
      return (32'(sel) < nch);
   endfunction
endpackage

// File: rtl/dm1_7_slot.sv
// One-entry channel buffer: holding register plus full flag, fill wins over drain.
module dm_slot #(
   parameter int unsigned DW = dm1_7_pkg::DW
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          fill,
   input  logic [DW-1:0] data,
   input  logic          drain,
   output logic          full,
   output logic [DW-1:0] q
);
   logic          full_q, full_d;
   logic [DW-1:0] q_q, q_d;

   always_comb begin
      full_d = full_q;
      q_d    = q_q;
      if (fill) begin
         full_d = 1'b1;
         q_d    = data;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         full_q <= 1'b0;
         q_q    <= '0;
      end else begin
         full_q <= full_d;
         q_q    <= q_d;
      end
   end

   assign full = full_q;
   assign q    = q_q;
endmodule

// File: rtl/dm1_7.sv
// Demultiplexer distributing one input word into NCH one-entry channel buffers.
module dm1_7 #(
   parameter int unsigned DW  = dm1_7_pkg::DW,
   parameter int unsigned NCH = dm1_7_pkg::NCH
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic [DW-1:0]                   I_DATA,
   input  logic [dm1_7_pkg::SEL_W-1:0]     I_SEL,
   input  logic                            I_VALID,
   output logic                            I_READY,
   output logic [NCH*DW-1:0]               O_DATA,
   output logic [NCH-1:0]                  O_VALID,
   input  logic [NCH-1:0]                  O_READY,
   output logic                            ERR,
   input  logic                            ERR_CLR,
   output logic [dm1_7_pkg::CNT_W-1:0]     ACC_CNT
);
   localparam int unsigned SW = dm1_7_pkg::SEL_W;
   localparam int unsigned CW = dm1_7_pkg::CNT_W;

   logic [NCH-1:0] full;
   logic [NCH-1:0] fill_c;
   logic [NCH-1:0] drain_c;
   logic           in_range_c;
   logic           xfer_c;
   logic           err_q, err_d;
   logic [CW-1:0]  acc_q, acc_d;

   // Out-of-range selects are always accepted and discarded.
   always_comb begin
      in_range_c = dm1_7_pkg::sel_in_range(I_SEL, NCH);
      I_READY    = 1'b1;
      for (int k = 0; k < int'(NCH); k++) begin
         if (I_SEL == SW'(k)) I_READY = !full[k] || O_READY[k];
      end
      xfer_c = I_VALID && I_READY;
      for (int k = 0; k < int'(NCH); k++) begin
         fill_c[k]  = xfer_c && (I_SEL == SW'(k));
         drain_c[k] = full[k] && O_READY[k];
      end
   end

   always_comb begin
      err_d = err_q;
      acc_d = acc_q;
      if (ERR_CLR) err_d = 1'b0;
      if (xfer_c && !in_range_c) err_d = 1'b1;
      if (xfer_c && in_range_c) acc_d = acc_q + CW'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_q <= 1'b0;
         acc_q <= '0;
      end else begin
         err_q <= err_d;
         acc_q <= acc_d;
      end
   end

   for (genvar k = 0; k < int'(NCH); k++) begin : g_slot
      dm_slot #(.DW(DW)) u_slot (
         .CLK   (CLK),
         .RST_N (RST_N),
         .fill  (fill_c[k]),
         .data  (I_DATA),
         .drain (drain_c[k]),
         .full  (full[k]),
         .q     (O_DATA[k*DW +: DW])
      );
   end

   assign O_VALID = full;
   assign ERR     = err_q;
   assign ACC_CNT = acc_q;
endmodule

// File: tb/tb_dm1_7.sv
// Bench for dm1_7: array-based channel model checked every cycle plus directed literal checks.
module tb_dm1_7;
   localparam int DW  = 16;
   localparam int NCH = 7;

   logic              CLK = 1'b0;
   logic              RST_N;
   logic [DW-1:0]     I_DATA;
   logic [2:0]        I_SEL;
   logic              I_VALID;
   logic              I_READY;
   logic [NCH*DW-1:0] O_DATA;
   logic [NCH-1:0]    O_VALID;
   logic [NCH-1:0]    O_READY;
   logic              ERR;
   logic              ERR_CLR;
   logic [15:0]       ACC_CNT;

   dm1_7 dut (
      .CLK(CLK), .RST_N(RST_N), .I_DATA(I_DATA), .I_SEL(I_SEL), .I_VALID(I_VALID),
      .I_READY(I_READY), .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
      .ERR(ERR), .ERR_CLR(ERR_CLR), .ACC_CNT(ACC_CNT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic          full_m [NCH];
   logic [DW-1:0] hold_m [NCH];
   logic          err_m;
   logic [15:0]   acc_m;
   logic          last_ready;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         full_m[k] = 1'b0;
         hold_m[k] = '0;
      end
      err_m = 1'b0;
      acc_m = '0;
   endtask

   function automatic logic model_ready(input logic [2:0] sel, input logic [NCH-1:0] ordy);
      if (int'(sel) >= NCH) return 1'b1;
      return !full_m[sel] || ordy[sel];
   endfunction

   task automatic compare_all();
      logic [NCH*DW-1:0] exp_data;
      logic [NCH-1:0]    exp_valid;
      for (int k = 0; k < NCH; k++) begin
         exp_data[k*DW +: DW] = hold_m[k];
         exp_valid[k]         = full_m[k];
      end
      chk("o_valid", O_VALID, exp_valid);
      chk("o_data", O_DATA, exp_data);
      chk("err", ERR, err_m);
      chk("acc_cnt", ACC_CNT, acc_m);
   endtask

   // Drive one cycle from a negedge, check ready, apply edge to model, compare at next negedge.
   task automatic cycle(input logic [2:0] sel, input logic [DW-1:0] data, input logic valid,
                        input logic [NCH-1:0] ordy, input logic clr);
      logic rdy;
      I_SEL = sel; I_DATA = data; I_VALID = valid; O_READY = ordy; ERR_CLR = clr;
      #1;
      rdy = model_ready(sel, ordy);
      last_ready = I_READY;
      chk("i_ready", I_READY, rdy);
      @(posedge CLK);
      for (int k = 0; k < NCH; k++) begin
         if (valid && rdy && int'(sel) == k) begin
            full_m[k] = 1'b1;
            hold_m[k] = data;
         end else if (full_m[k] && ordy[k]) begin
            full_m[k] = 1'b0;
         end
      end
      if (clr) err_m = 1'b0;
      if (valid && rdy && int'(sel) >= NCH) err_m = 1'b1;
      if (valid && rdy && int'(sel) < NCH) acc_m = acc_m + 16'd1;
      @(negedge CLK);
      compare_all();
   endtask

   initial begin
      RST_N = 1'b0; I_SEL = 3'd3; I_DATA = 16'hAAAA; I_VALID = 1'b1; O_READY = '0; ERR_CLR = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      chk("reset_ready", I_READY, 1'b1);
      compare_all();
      RST_N = 1'b1;

      // Single word into channel 2, one-clock latency.
      cycle(3'd2, 16'hBEEF, 1'b1, 7'h00, 1'b0);
      chk("lit_valid_ch2", O_VALID, 7'b0000100);
      chk("lit_slice2_beef", O_DATA[47:32], 16'hBEEF);
      chk("lit_acc1", ACC_CNT, 16'd1);

      // Stalled channel blocks its own selects; drain and refill share an edge.
      cycle(3'd2, 16'h1111, 1'b1, 7'h00, 1'b0);
      chk("lit_stall_ready", last_ready, 1'b0);
      chk("lit_stall_hold", O_DATA[47:32], 16'hBEEF);
      cycle(3'd2, 16'h1234, 1'b1, 7'b0000100, 1'b0);
      chk("lit_pass_ready", last_ready, 1'b1);
      chk("lit_nobubble", O_VALID[2], 1'b1);
      chk("lit_slice2_1234", O_DATA[47:32], 16'h1234);

      // Other channels proceed while channel 2 is stalled.
      cycle(3'd5, 16'h0055, 1'b1, 7'h00, 1'b0);
      chk("lit_indep_ready", last_ready, 1'b1);
      chk("lit_valid_2_5", O_VALID, 7'b0100100);
      chk("lit_slice5", O_DATA[95:80], 16'h0055);

      // Out-of-range select: discarded, sticky ERR, set wins over clear.
      cycle(3'd7, 16'hDEAD, 1'b1, 7'h00, 1'b0);
      chk("lit_oor_ready", last_ready, 1'b1);
      chk("lit_err_set", ERR, 1'b1);
      chk("lit_oor_valid", O_VALID, 7'b0100100);
      chk("lit_oor_acc", ACC_CNT, 16'd3);
      cycle(3'd7, 16'hDEAD, 1'b1, 7'h00, 1'b1);
      chk("lit_err_setwins", ERR, 1'b1);
      cycle(3'd0, 16'h0000, 1'b0, 7'h00, 1'b1);
      chk("lit_err_clr", ERR, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         cycle(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
               7'($urandom), ($urandom_range(0, 15) == 0));
      end

      // Fill every channel, then reset asynchronously between edges.
      cycle(3'd0, 16'h0000, 1'b0, 7'h7F, 1'b0);
      for (int k = 0; k < NCH; k++) cycle(3'(k), 16'($urandom) | 16'h0001, 1'b1, 7'h00, 1'b0);
      chk("lit_all_full", O_VALID, 7'h7F);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      chk("lit_arst_valid", O_VALID, 7'h00);
      chk("lit_arst_data", O_DATA, 112'h0);
      chk("lit_arst_acc", ACC_CNT, 16'h0000);
      chk("lit_arst_ready", I_READY, 1'b1);
      @(negedge CLK);
      compare_all();
      RST_N = 1'b1;

      // Counter wrap after 65536 in-range transfers.
      for (int i = 0; i < 65535; i++) cycle(3'(i % NCH), 16'($urandom), 1'b1, 7'h7F, 1'b0);
      chk("lit_acc_ffff", ACC_CNT, 16'hFFFF);
      cycle(3'd4, 16'h4444, 1'b1, 7'h7F, 1'b0);
      chk("lit_acc_wrap", ACC_CNT, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm1_7.md
DM1_7 -- requirements
Module: dm1_7

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning data width per channel.
REQ-002 The block SHALL have parameter NCH, default 7, meaning number of output channels; legal selects are 0..NCH-1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port I_DATA, input, DW bits: the word to distribute.
REQ-006 The block SHALL have port I_SEL, input, 3 bits: the destination channel.
REQ-007 The block SHALL have port I_VALID, input, 1 bit: I_DATA/I_SEL are valid.
REQ-008 The block SHALL have port I_READY, output, 1 bit: the block accepts this cycle.
REQ-009 The block SHALL have port O_DATA, output, NCH*DW bits: channel k occupies bits [k*DW+DW-1 : k*DW].
REQ-010 The block SHALL have port O_VALID, output, NCH bits: channel k holds a word.
REQ-011 The block SHALL have port O_READY, input, NCH bits: the consumer of channel k takes the word.
REQ-012 The block SHALL have port ERR, output, 1 bit: sticky flag, an out-of-range select was accepted.
REQ-013 The block SHALL have port ERR_CLR, input, 1 bit: synchronous clear of ERR.
REQ-014 The block SHALL have port ACC_CNT, output, 16 bits: count of words delivered into channels.

Function
REQ-015 Each channel SHALL be a one-entry buffer: a DW-bit holding register plus a full flag; O_VALID[k] = full[k], and O_DATA slice k = holding[k].
REQ-016 A transfer SHALL occur on a rising edge when I_VALID=1 and I_READY=1.
REQ-017 For I_SEL<NCH, I_READY SHALL be combinational: !full[I_SEL] || O_READY[I_SEL].
REQ-018 For I_SEL>=NCH (i.e. 7), I_READY SHALL be 1; the word is discarded, no channel changes, and ERR is set on the next edge.
REQ-019 Channel k SHALL drain on an edge where O_VALID[k]=1 and O_READY[k]=1, clearing full[k] unless a fill to k occurs on the same edge.
REQ-020 A simultaneous drain and fill of the same channel SHALL load the new word and keep full[k]=1, with no bubble.
REQ-021 Latency from an accepted input to O_VALID SHALL be one clock.
REQ-022 Words to the same channel SHALL leave in acceptance order; channels SHALL be independent, and a stalled channel SHALL block only inputs that select it.
REQ-023 Holding registers SHALL load only on a fill, so O_DATA slice k stays stable while O_VALID[k]=1 and O_READY[k]=0.
REQ-024 ACC_CNT SHALL increment by 1 on each transfer with I_SEL<NCH and wrap from 16'hFFFF to 0; discarded words SHALL not count.
REQ-025 When ERR_CLR=1 and an out-of-range transfer occur on the same edge, ERR SHALL be 1 (set wins).
REQ-026 I_READY SHALL not depend on I_VALID.

Reset
REQ-027 While RST_N=0, asynchronously: full flags=0, so O_VALID=0; holding registers=0, so O_DATA=0; ERR=0; ACC_CNT=0.
REQ-028 Reset mid-operation SHALL discard all buffered words without delivering them; the first edge after deassertion SHALL behave as from the empty state.
REQ-029 While in reset, I_READY SHALL equal its combinational value for the empty state, but no transfer SHALL be recorded.

Structure
REQ-030 Constants DW=16, NCH=7 and SEL_W=3 SHALL reside in a shared datapath package, which the processor datapath muxes also use.
REQ-031 The per-channel buffer SHALL be one sub-module, dm_slot, instantiated NCH times with ports CLK, RST_N, fill, data, drain, full, q.

Verification
REQ-032 Reset, then I_SEL=2, I_DATA=16'hBEEF, I_VALID=1 for one cycle with O_READY=0 -> next cycle O_VALID=7'b0000100, slice 2=BEEF, ACC_CNT=1.
REQ-033 Channel 2 full, O_READY[2]=0, I_SEL=2 -> I_READY=0 and the data holds; raise O_READY[2] with I_DATA=16'h1234 -> same edge drains BEEF and loads 1234, O_VALID[2] stays 1.
REQ-034 Channel 2 stalled full, I_SEL=5, I_DATA=16'h0055 -> I_READY=1, and channel 5 is valid next cycle with 0055.
REQ-035 I_SEL=7, I_DATA=16'hDEAD, I_VALID=1 -> I_READY=1, ERR=1 next cycle, no O_VALID change, ACC_CNT unchanged; ERR_CLR together with a second I_SEL=7 -> ERR stays 1; ERR_CLR alone -> ERR=0.
REQ-036 Preload ACC_CNT to FFFF via 65535 transfers, then one more transfer -> ACC_CNT=0.
REQ-037 Fill channels 0..6, then pulse RST_N low mid-cycle -> O_VALID=0, O_DATA=0, ACC_CNT=0 immediately, without waiting for a clock.
